// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined add/sub/compare/AND ALU; ALU_ACC_EN adds an accumulator operand.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] bit1,
  input  logic [WIDTH-1:0] bit2,
`ifdef ALU_ACC_EN
  input  logic             acc_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             equal,
  output logic             greater,
  output logic             lesser
);
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, a;
  logic [WIDTH:0]   res;
  logic             s2_load;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
`ifdef ALU_ACC_EN
  logic             s1_acc;
  logic [WIDTH-1:0] acc;
  assign a = s1_acc ? acc : s1_a;
  always_ff @(posedge clk)
    if (reset) acc <= '0;
    else if (s2_load) acc <= res[WIDTH-1:0];
`else
  assign a = s1_a;
`endif
  // subtracting in WIDTH+1 bits leaves the borrow (a < b) in the MSB
  always_comb
    res = s1_op == 2'b00 ? {1'b0, a} + {1'b0, s1_b} :
          s1_op == 2'b01 ? {1'b0, a} - {1'b0, s1_b} :
          s1_op == 2'b10 ? '0 : {1'b0, a & s1_b};
  always_ff @(posedge clk)
    if (reset) s1_valid <= 1'b0;
    else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_a  <= bit1;
        s1_b  <= bit2;
`ifdef ALU_ACC_EN
        s1_acc <= acc_sel;
`endif
      end
    end
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      lesser    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= res;
      equal     <= a == s1_b;
      greater   <= a > s1_b;
      lesser    <= a < s1_b;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
